// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode encoding, control
// states, flag bit positions and the shift-amount width helper.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  // log2 of a power-of-two width: number of bits in a shift amount
  function automatic int shamt_w(input int w);
    int r;
    r = 0;
    while ((1 << r) < w) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier, one partial product per clock. done marks the
// edge on which the final product (presented on prod) becomes complete.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CNT_W = shamt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] sum;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               run_q, run_d;

  always_comb begin
    sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      acc_d    = '0;
      mplier_d = b;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) run_d = 1'b0;
    end
  end

  // The last iteration's sum is handed straight out so the top can capture
  // the product on the same edge the counter expires.
  assign done = run_q && (cnt_q == LAST);
  assign prod = sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Execute-stage ALU with valid/ready on both sides: single-cycle logic and
// arithmetic ops plus an optional iterative multiply, registered result and Z/N/C/V.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             err,
  output logic             busy
);

  localparam int SW  = shamt_w(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_state_e         state_q, state_d;
  logic               vld_q, vld_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [3:0]         flags_q, flags_d;
  logic               err_q, err_d;

  alu_op_e            op_e;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [SW-1:0]      shamt;
  logic [WIDTH:0]     sum_ext, shl, shr;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v, alu_err;

  function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  assign op_e      = alu_op_e'(op);
  assign shamt     = b[SW-1:0];
  assign in_ready  = (state_q == ST_IDLE) && (!vld_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (op_e == OP_MUL) && (MUL_EN != 0);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (mul_prod)
  );

  always_comb begin
    sum_ext = '0;
    shl     = '0;
    shr     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (op_e)
      OP_ADD: begin
        sum_ext = {1'b0, a} + {1'b0, b};
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sum_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
      end
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      // Widening by one bit catches the last bit shifted out; it stays 0 for s=0.
      OP_SLL: begin
        shl     = {1'b0, a} << shamt;
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      OP_SRL: begin
        shr     = {a, 1'b0} >> shamt;
        alu_res = shr[WIDTH:1];
        alu_c   = shr[0];
      end
      OP_MUL: alu_err = (MUL_EN == 0);
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (mul_start) begin
          state_d = ST_MUL;
          vld_d   = 1'b0;
        end else if (accept) begin
          vld_d   = 1'b1;
          res_d   = alu_res;
          flags_d = pack_flags(alu_res, alu_c, alu_v);
          err_d   = alu_err;
        end else if (out_ready) begin
          vld_d   = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_IDLE;
          vld_d   = 1'b1;
          res_d   = mul_prod[WIDTH-1:0];
          flags_d = pack_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
          err_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vld_q   <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_n    = flags_q[FLAG_N];
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign err       = err_q;
  assign busy      = (state_q == ST_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: arithmetic reference model with a per-cycle compare,
// directed literal cases, randomized traffic, and a MUL_EN=0 instance.
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         in_ready, out_valid, flag_z, flag_n, flag_c, flag_v, err, busy;
  logic [W-1:0] result;

  logic         in_valid2, out_ready2;
  logic [2:0]   op2;
  logic [W-1:0] a2, b2;
  logic         in_ready2, out_valid2, flag_z2, flag_n2, flag_c2, flag_v2, err2, busy2;
  logic [W-1:0] result2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .err(err), .busy(busy)
  );

  alu_pipe #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .op(op2),
    .a(a2), .b(b2), .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
    .flag_z(flag_z2), .flag_n(flag_n2), .flag_c(flag_c2), .flag_v(flag_v2),
    .err(err2), .busy(busy2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [W-1:0] res;
    logic z, n, c, v, err;
  } exp_t;

  // Reference arithmetic on plain integers, signed overflow judged by range.
  function automatic exp_t ref_op(input logic [2:0] o, input longint ua, input longint ub,
                                  input bit mul_en);
    longint mask, r, sa, sb, sr, smax, smin;
    int     s;
    exp_t   e;
    e    = '0;
    mask = (longint'(1) << W) - 1;
    smax = (longint'(1) << (W - 1)) - 1;
    smin = -(longint'(1) << (W - 1));
    sa   = (ua > smax) ? ua - (longint'(1) << W) : ua;
    sb   = (ub > smax) ? ub - (longint'(1) << W) : ub;
    s    = int'(ub % W);
    r    = 0;
    case (o)
      3'd0: begin r = ua + ub; e.c = ((r >> W) & 1) != 0; sr = sa + sb; e.v = (sr > smax) || (sr < smin); end
      3'd1: begin r = ua + ((~ub) & mask) + 1; e.c = ((r >> W) & 1) != 0; sr = sa - sb; e.v = (sr > smax) || (sr < smin); end
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: begin r = ua << s; e.c = (s != 0) && (((ua >> (W - s)) & 1) != 0); end
      3'd6: begin r = ua >> s; e.c = (s != 0) && (((ua >> (s - 1)) & 1) != 0); end
      default: begin
        if (mul_en) begin r = ua * ub; e.c = (r >> W) != 0; end
        else        begin r = 0; e.err = 1'b1; end
      end
    endcase
    e.res = W'(r & mask);
    e.z   = (e.res == '0);
    e.n   = e.res[W-1];
    return e;
  endfunction

  exp_t m_out, m_pend, m_tmp;
  bit   m_vld;
  int   mul_left;
  bit   m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld    <= 1'b0;
      mul_left <= 0;
      m_out    <= '0;
    end else begin
      m_rdy = (mul_left == 0) && (!m_vld || out_ready);
      m_tmp = ref_op(op, longint'(a), longint'(b), 1'b1);
      if (mul_left > 0) begin
        mul_left <= mul_left - 1;
        if (mul_left == 1) begin
          m_vld <= 1'b1;
          m_out <= m_pend;
        end
      end else if (in_valid && m_rdy) begin
        if (op == 3'd7) begin
          m_pend   <= m_tmp;
          mul_left <= W;
          m_vld    <= 1'b0;
        end else begin
          m_out <= m_tmp;
          m_vld <= 1'b1;
        end
      end else if (out_ready) begin
        m_vld <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, (mul_left == 0) && (!m_vld || out_ready));
    chk("out_valid", out_valid, m_vld);
    chk("busy", busy, mul_left > 0);
    if (m_vld || !rst_n) begin
      chk("result", result, m_out.res);
      chk("flags_zncv", {flag_z, flag_n, flag_c, flag_v}, {m_out.z, m_out.n, m_out.c, m_out.v});
      chk("err", err, m_out.err);
    end
  end

  task automatic sync;
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    bit acc;
    int n;
    in_valid = 1'b1; op = o; a = x; b = y;
    n = 0;
    forever begin
      @(negedge clk);
      acc = in_ready;
      sync();
      if (acc) break;
      n++;
      if (n > 50) begin
        chk("issue_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!out_valid && cyc < 40);
    chk("wait_out_valid", out_valid, 1);
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] r, input logic [3:0] zncv);
    chk({tag, "_result"}, result, r);
    chk({tag, "_zncv"}, {flag_z, flag_n, flag_c, flag_v}, zncv);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; op2 = '0; a2 = '0; b2 = '0; out_ready2 = 1'b1;
    repeat (3) sync();
    chk("reset_result", result, 0);
    chk("reset_valid", out_valid, 0);
    rst_n = 1'b1;
    sync();

    issue(3'd0, 16'h7FFF, 16'h0001);
    wait_out(cyc);
    chk("add_latency", cyc, 1);
    check_out("add_ovf", 16'h8000, 4'b0101);
    sync();

    issue(3'd1, 16'h0005, 16'h0005);
    wait_out(cyc);
    check_out("sub_eq", 16'h0000, 4'b1010);
    sync();
    issue(3'd1, 16'h0003, 16'h0005);
    wait_out(cyc);
    check_out("sub_borrow", 16'hFFFE, 4'b0100);
    sync();

    issue(3'd7, 16'd300, 16'd300);
    @(negedge clk);
    chk("mul_busy", busy, 1);
    chk("mul_in_ready", in_ready, 0);
    wait_out(cyc);
    chk("mul_latency", cyc, W);
    check_out("mul", 16'h5F90, 4'b0010);
    chk("mul_busy_done", busy, 0);
    sync();

    out_ready = 1'b0;
    issue(3'd0, 16'h0001, 16'h0002);
    repeat (3) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_result", result, 16'h0003);
      chk("bp_in_ready", in_ready, 0);
    end
    sync();
    out_ready = 1'b1;
    issue(3'd3, 16'h00F0, 16'h000F);
    wait_out(cyc);
    chk("bp_same_edge", cyc, 1);
    check_out("or", 16'h00FF, 4'b0000);
    sync();

    issue(3'd5, 16'h8001, 16'h0001);
    wait_out(cyc);
    check_out("sll1", 16'h0002, 4'b0010);
    sync();
    issue(3'd6, 16'h0001, 16'h0000);
    wait_out(cyc);
    check_out("srl0", 16'h0001, 4'b0000);
    sync();
    issue(3'd6, 16'h00F0, 16'h0004);
    wait_out(cyc);
    check_out("srl4", 16'h000F, 4'b0000);
    sync();

    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom % 3) != 0;
      op        = 3'($urandom % 8);
      case ($urandom % 4)
        0:       a = (($urandom % 2) != 0) ? 16'h7FFF : 16'h8000;
        1:       a = (($urandom % 2) != 0) ? 16'hFFFF : 16'h0000;
        default: a = W'($urandom);
      endcase
      b         = (($urandom % 5) == 0) ? a : W'($urandom);
      out_ready = ($urandom % 4) != 0;
      sync();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (W + 4) sync();

    issue(3'd7, 16'd300, 16'd7);
    repeat (7) sync();
    rst_n = 1'b0;
    #1;
    chk("rst_mul_busy", busy, 0);
    chk("rst_mul_valid", out_valid, 0);
    chk("rst_mul_result", result, 0);
    chk("rst_mul_flags", {flag_z, flag_n, flag_c, flag_v, err}, 0);
    sync();
    sync();
    rst_n = 1'b1;
    repeat (W + 4) begin
      @(negedge clk);
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_ready", in_ready, 1);
    end
    sync();

    in_valid2 = 1'b1; op2 = 3'd7; a2 = 16'h1234; b2 = 16'h0005;
    @(negedge clk);
    chk("nomul_ready", in_ready2, 1);
    sync();
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("nomul_valid", out_valid2, 1);
    chk("nomul_err", err2, 1);
    chk("nomul_result", result2, 16'h0000);
    chk("nomul_zncv", {flag_z2, flag_n2, flag_c2, flag_v2}, 4'b1000);
    chk("nomul_busy", busy2, 0);
    sync();
    sync();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, handshaked successor to the core 16-bit datapath ALU.
- Adds XOR, logical shifts and an iterative multiply.
- Produces a full registered flag set (Z/N/C/V).
- Uses valid/ready handshakes on both sides so the control FSM and the writeback stage can stall it.
- Sits between operand fetch and register writeback in the execute stage.

Parameters:
WIDTH, 16, datapath width in bits; must be >= 4 and a power of two.
MUL_EN, 1, 1 = iterative multiplier present; 0 = MUL opcode is illegal.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and op are valid this cycle
in_ready  output  1  block can accept an operation this cycle
op  input  3  operation code, encoding below
a  input  WIDTH  operand A
b  input  WIDTH  operand B; low log2(WIDTH) bits give the shift amount for shifts
out_valid  output  1  result and flags are valid
out_ready  input  1  consumer takes the result this cycle
result  output  WIDTH  registered result
flag_z  output  1  result == 0
flag_n  output  1  result MSB
flag_c  output  1  carry / shift-out / multiply-high-nonzero
flag_v  output  1  signed overflow (ADD/SUB only)
err  output  1  illegal op; qualified by out_valid
busy  output  1  multiply in progress

Behaviour:
- Reset: asynchronous on rst_n low. result=0, all flags=0, err=0, out_valid=0, busy=0, FSM=IDLE, multiplier state cleared. Reset mid-multiply aborts the operation; nothing is output afterwards.
- Op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 MUL.
- Accept: an op is taken when in_valid && in_ready on a rising edge.
- in_ready = !busy && (!out_valid || out_ready). This allows back-to-back single-cycle ops at full rate.
- FSM states:
  - IDLE/HOLD: default state.
  - MUL: entered on an accepted MUL when MUL_EN=1. Counts WIDTH iterations, then returns.
- Single-cycle ops: result, flags and out_valid are registered on the accept edge, so latency is 1.
- MUL latency: busy=1 from the edge after accept. out_valid rises WIDTH cycles after the accept edge; busy falls on that same edge.
- Output hold: while out_valid && !out_ready, result, flags and err stay stable. out_valid clears on an out_ready edge unless a new op is accepted on that same edge.
- ADD/SUB: WIDTH+1-bit arithmetic. SUB is computed as a + ~b + 1.
  - flag_c = carry out; for SUB, 1 means no borrow.
  - flag_v = signed overflow.
- AND/OR/XOR: flag_c = 0, flag_v = 0.
- SLL/SRL: shift amount s = b[log2(WIDTH)-1:0], zero fill.
  - flag_c = last bit shifted out; 0 when s = 0.
  - flag_v = 0.
- MUL: unsigned shift-add, 1 bit per cycle. result = low WIDTH bits of the product; flag_c = 1 if the high WIDTH bits are nonzero; flag_v = 0.
- MUL_EN=0 with op=111: 1-cycle response, result=0, err=1, all flags 0 except flag_z=1.
- flag_z and flag_n are always derived from the registered result.
- Inputs with in_valid low are ignored; op/a/b may change freely.

Decomposition:
- alu_pkg: op encoding constants, state enum, flag bit positions, SHAMT_W = log2(WIDTH) constant function.
- Sub-module alu_mul_seq (WIDTH) holds the iterative multiplier: start, a, b -> done, prod[2*WIDTH-1:0].
- alu_pipe contains the handshake, FSM, single-cycle ops and flag logic.

Test Plan:
1. ADD a=0x7FFF b=0x0001 -> 1 cycle later out_valid=1, result=0x8000, N=1, V=1, C=0, Z=0.
2. SUB a=0x0005 b=0x0005 -> result=0x0000, Z=1, C=1, V=0. Then SUB 0x0003-0x0005 -> result=0xFFFE, N=1, C=0.
3. MUL a=300 b=300 -> busy=1 and in_ready=0 for 16 cycles; out_valid 16 cycles after accept; result=0x5F90, C=1.
4. Backpressure: ADD 1+2 with out_ready=0 for 3 cycles -> result=0x0003 held stable, in_ready=0. Raise out_ready while presenting OR 0x00F0|0x000F -> accepted the same edge; next result=0x00FF.
5. Shifts: SLL 0x8001 by 1 -> 0x0002, C=1. SRL 0x0001 by 0 -> 0x0001, C=0. SRL 0x00F0 by 4 -> 0x000F, C=0.
6. Reset: assert rst_n=0 at iteration 7 of MUL -> all outputs 0 immediately; after release, in_ready=1 and no stale out_valid. MUL_EN=0 build: op=111 -> err=1, result=0, Z=1.
